// File: rtl/ex_result_fwd_src_pkg.sv
// Shared definitions for the EX result forwarding source.
//  - default datapath / register-address widths
//  - load-wait timeout and wait-counter width defaults
//  - FSM state encoding
//  - the hard-wired zero register index
package ex_result_fwd_src_pkg;

  localparam int FWD_XLEN         = 32;
  localparam int FWD_REG_AW       = 5;
  localparam int FWD_LOAD_TIMEOUT = 255;
  localparam int FWD_CNT_W        = 8;

  localparam logic [FWD_REG_AW-1:0] REG_X0 = '0;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } fwd_state_t;

endpackage

// File: rtl/ex_result_fwd_src_fwd_hz_cmp.sv
// Load-use hazard compare: pending destination registers vs the two ID
// source registers. One slot today; NUM_SLOTS leaves room for a second
// outstanding load without touching the top.
//  slot_vld  in   NUM_SLOTS           slot holds a live, non-x0 pending rd
//  slot_rd   in   NUM_SLOTS x REG_AW  pending destination per slot
//  rs1, rs2  in   REG_AW              sources being read in ID
//  hit       out  1                   any live slot matches rs1 or rs2
module ex_result_fwd_src_fwd_hz_cmp #(
  parameter int REG_AW    = 5,
  parameter int NUM_SLOTS = 1
) (
  input  logic [NUM_SLOTS-1:0]             slot_vld,
  input  logic [NUM_SLOTS-1:0][REG_AW-1:0] slot_rd,
  input  logic [REG_AW-1:0]                rs1,
  input  logic [REG_AW-1:0]                rs2,
  output logic                             hit
);

  logic [NUM_SLOTS-1:0] slot_hit;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    assign slot_hit[s] = slot_vld[s] & ((slot_rd[s] == rs1) | (slot_rd[s] == rs2));
  end

  assign hit = |slot_hit;

endmodule

// File: rtl/ex_result_fwd_src.sv
// Producer end of the EX->ID operand-forwarding bus.
// ALU results retire the cycle after acceptance; loads park in WAIT_LOAD
// until the memory response arrives (or time out). The retiring value is
// driven on the forwarding bus and, identically, on the REGS write port.
//  clk, rst_n                 clock / async active-low reset
//  ex_valid/ex_ready          EX handshake (ready only in IDLE)
//  ex_rd/ex_is_load/ex_alu_result  retiring instruction
//  mem_rsp_vld/mem_rsp_data   load data return (1-cycle pulse)
//  id_rs1/id_rs2              ID source registers, for load-use stall
//  hz_stall                   load-use stall request (comb)
//  EX_rd/EX_x_rd/EX_x_rd_vld  forwarding bus (vld is a 1-cycle pulse)
//  wb_we/wb_waddr/wb_wdata    REGS write port, mirrors the forwarding bus
//  bus_err                    sticky: load timeout or spurious response
module ex_result_fwd_src
  import ex_result_fwd_src_pkg::*;
#(
  parameter int XLEN         = FWD_XLEN,
  parameter int REG_AW       = FWD_REG_AW,
  parameter int LOAD_TIMEOUT = FWD_LOAD_TIMEOUT,
  parameter int CNT_W        = FWD_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic              mem_rsp_vld,
  input  logic [XLEN-1:0]   mem_rsp_data,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              hz_stall,
  output logic [REG_AW-1:0] EX_rd,
  output logic [XLEN-1:0]   EX_x_rd,
  output logic              EX_x_rd_vld,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_waddr,
  output logic [XLEN-1:0]   wb_wdata,
  output logic              bus_err
);

  localparam logic [REG_AW-1:0] RD_X0   = REG_AW'(REG_X0);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LOAD_TIMEOUT);

  fwd_state_t        state;
  logic [REG_AW-1:0] pend_rd;
  logic [CNT_W-1:0]  wait_cnt;

  assign ex_ready = (state == ST_IDLE);

  // Stall drops in the response cycle: the forwarding bus carries the
  // load data on the very next cycle, which is when ID re-reads.
  logic [0:0]             slot_vld;
  logic [0:0][REG_AW-1:0] slot_rd;

  assign slot_vld[0] = (state == ST_WAIT_LOAD) & ~mem_rsp_vld & (pend_rd != RD_X0);
  assign slot_rd[0]  = pend_rd;

  ex_result_fwd_src_fwd_hz_cmp #(
    .REG_AW    (REG_AW),
    .NUM_SLOTS (1)
  ) u_hz_cmp (
    .slot_vld (slot_vld),
    .slot_rd  (slot_rd),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .hit      (hz_stall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pend_rd     <= '0;
      wait_cnt    <= '0;
      EX_rd       <= '0;
      EX_x_rd     <= '0;
      EX_x_rd_vld <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      EX_x_rd_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          // No load outstanding, so any response here is spurious.
          if (mem_rsp_vld) bus_err <= 1'b1;
          if (ex_valid) begin
            if (ex_is_load) begin
              state    <= ST_WAIT_LOAD;
              pend_rd  <= ex_rd;
              wait_cnt <= '0;
            end else if (ex_rd != RD_X0) begin
              EX_x_rd_vld <= 1'b1;
              EX_rd       <= ex_rd;
              EX_x_rd     <= ex_alu_result;
            end
          end
        end
        ST_WAIT_LOAD: begin
          // Response is checked first so it beats a same-cycle timeout.
          if (mem_rsp_vld) begin
            state <= ST_IDLE;
            if (pend_rd != RD_X0) begin
              EX_x_rd_vld <= 1'b1;
              EX_rd       <= pend_rd;
              EX_x_rd     <= mem_rsp_data;
            end
          end else if (wait_cnt == CNT_MAX) begin
            state   <= ST_IDLE;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wb_we    = EX_x_rd_vld;
  assign wb_waddr = EX_rd;
  assign wb_wdata = EX_x_rd;

endmodule

// File: tb/tb_ex_result_fwd_src.sv
module tb_ex_result_fwd_src;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [4:0]  ex_rd = '0;
  logic        ex_is_load = 1'b0;
  logic [31:0] ex_alu_result = '0;
  logic        mem_rsp_vld = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic        hz_stall;
  logic [4:0]  EX_rd;
  logic [31:0] EX_x_rd;
  logic        EX_x_rd_vld;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        bus_err;

  int checks = 0;
  int failures = 0;

  // Reference model: "is a load outstanding, for whom, how long waited",
  // plus the last value seen on the bus.
  bit          m_busy;
  logic [4:0]  m_pend;
  int          m_waited;
  bit          m_vld;
  logic [4:0]  m_rd;
  logic [31:0] m_x;
  bit          m_err;

  always #5 clk = ~clk;

  ex_result_fwd_src dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_rd         (ex_rd),
    .ex_is_load    (ex_is_load),
    .ex_alu_result (ex_alu_result),
    .mem_rsp_vld   (mem_rsp_vld),
    .mem_rsp_data  (mem_rsp_data),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .hz_stall      (hz_stall),
    .EX_rd         (EX_rd),
    .EX_x_rd       (EX_x_rd),
    .EX_x_rd_vld   (EX_x_rd_vld),
    .wb_we         (wb_we),
    .wb_waddr      (wb_waddr),
    .wb_wdata      (wb_wdata),
    .bus_err       (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_pend = '0; m_waited = 0;
    m_vld = 0; m_rd = '0; m_x = '0; m_err = 0;
  endtask

  task automatic check_bus(input string tag);
    chk({tag, ".vld"},   {31'b0, EX_x_rd_vld}, {31'b0, m_vld});
    chk({tag, ".rd"},    {27'b0, EX_rd},       {27'b0, m_rd});
    chk({tag, ".x"},     EX_x_rd,              m_x);
    chk({tag, ".we"},    {31'b0, wb_we},       {31'b0, m_vld});
    chk({tag, ".waddr"}, {27'b0, wb_waddr},    {27'b0, m_rd});
    chk({tag, ".wdata"}, wb_wdata,             m_x);
    chk({tag, ".err"},   {31'b0, bus_err},     {31'b0, m_err});
  endtask

  // One clock: called at a negedge, drives inputs, checks comb outputs,
  // advances the model across the posedge, checks registered outputs.
  task automatic step(input string tag, input logic v, input logic ld,
                      input logic [4:0] rd, input logic [31:0] alu,
                      input logic rsp, input logic [31:0] data,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit exp_stall;
    ex_valid = v; ex_is_load = ld; ex_rd = rd; ex_alu_result = alu;
    mem_rsp_vld = rsp; mem_rsp_data = data; id_rs1 = r1; id_rs2 = r2;
    #1;
    exp_stall = m_busy && m_pend != 0 && !rsp && (r1 == m_pend || r2 == m_pend);
    chk({tag, ".ready"}, {31'b0, ex_ready}, {31'b0, !m_busy});
    chk({tag, ".stall"}, {31'b0, hz_stall}, {31'b0, exp_stall});
    m_vld = 0;
    if (!m_busy) begin
      if (rsp) m_err = 1;
      if (v && ld) begin
        m_busy = 1; m_pend = rd; m_waited = 0;
      end else if (v && rd != 0) begin
        m_vld = 1; m_rd = rd; m_x = alu;
      end
    end else if (rsp) begin
      m_busy = 0;
      if (m_pend != 0) begin m_vld = 1; m_rd = m_pend; m_x = data; end
    end else if (m_waited >= TMO) begin
      m_busy = 0; m_err = 1;
    end else begin
      m_waited++;
    end
    @(posedge clk); #1;
    check_bus(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 5'd0, 32'h0, 0, 32'h0, 5'd0, 5'd0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset(input string tag);
    ex_valid = 0; mem_rsp_vld = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    check_bus(tag);
    chk({tag, ".ready"}, {31'b0, ex_ready}, 32'd1);
    chk({tag, ".stall"}, {31'b0, hz_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset("rst0");

    // 1: ALU to x5
    step("t1.acc", 1, 0, 5'd5, 32'hDEADBEEF, 0, 32'h0, 5'd0, 5'd0);
    chk("t1.lit_x", EX_x_rd, 32'hDEADBEEF);
    idle("t1.after", 1);

    // 2: ALU to x0 never forwarded
    step("t2.acc", 1, 0, 5'd0, 32'h1234, 0, 32'h0, 5'd0, 5'd0);
    idle("t2.after", 2);

    // 3: load x7, ID reads x7 on rs2, response after 3 waiting cycles
    step("t3.acc", 1, 1, 5'd7, 32'hFFFF, 0, 32'h0, 5'd3, 5'd7);
    for (int i = 0; i < 3; i++) begin
      step("t3.wait", 1, 0, 5'd4, 32'h99, 0, 32'h0, 5'd3, 5'd7);
      chk("t3.lit_stall_pre", {31'b0, hz_stall}, 32'd1);
    end
    step("t3.rsp", 0, 0, 5'd0, 32'h0, 1, 32'h55AA, 5'd3, 5'd7);
    chk("t3.lit_x", EX_x_rd, 32'h55AA);
    idle("t3.after", 1);

    // 4: load x9 that never answers
    step("t4.acc", 1, 1, 5'd9, 32'h0, 0, 32'h0, 5'd9, 5'd0);
    idle("t4.wait", TMO + 1);
    chk("t4.lit_err", {31'b0, bus_err}, 32'd1);
    idle("t4.after", 1);

    // 5: spurious response in IDLE
    do_reset("t5.rst");
    step("t5.spur", 0, 0, 5'd0, 32'h0, 1, 32'hABCD, 5'd0, 5'd0);
    idle("t5.after", 1);

    // 6: reset abandons a pending load; its late response is spurious
    do_reset("t6.rst0");
    step("t6.acc", 1, 1, 5'd12, 32'h0, 0, 32'h0, 5'd12, 5'd12);
    idle("t6.wait", 2);
    do_reset("t6.rst");
    step("t6.late", 0, 0, 5'd0, 32'h0, 1, 32'h7777, 5'd12, 5'd0);

    // Response and timeout in the same cycle: response wins
    do_reset("t7.rst");
    step("t7.acc", 1, 1, 5'd3, 32'h0, 0, 32'h0, 5'd0, 5'd0);
    idle("t7.wait", TMO);
    step("t7.rsp", 0, 0, 5'd0, 32'h0, 1, 32'hCAFE0001, 5'd0, 5'd0);

    // Randomized traffic with periodic reset to keep bus_err informative
    for (int n = 0; n < 400; n++) begin
      logic v, ld, rsp;
      logic [4:0] rd, r1, r2;
      if (n % 40 == 0) do_reset("rnd.rst");
      v   = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 2) == 0);
      rsp = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 30) == 0);
      rd  = 5'($urandom_range(0, 7));
      r1  = 5'($urandom_range(0, 7));
      r2  = 5'($urandom_range(0, 7));
      step("rnd", v, ld, rd, $urandom, rsp, $urandom, r1, r2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
